// File: rtl/conv3x3_mac_ctrl.sv
// Sequencer for a 3x3 convolution MAC datapath: walks every valid window row-major,
// issues the 9 input/kernel reads, aligns accumulator control, hands off each result.
module conv3x3_mac_ctrl #(
  parameter int IMG_W   = 5,
  parameter int IMG_H   = 5,
  parameter int ADDR_W  = 8,
  parameter int OADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  in_addr,
  output logic [3:0]         w_addr,
  output logic               mac_en,
  output logic               acc_load,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OADDR_W-1:0] out_addr,
  output logic               busy,
  output logic               done
);

  // state    | meaning
  // IDLE     | waiting for start
  // ISSUE    | 9 read cycles, tap 0..8
  // DRAIN    | last product being accumulated
  // WAIT_OUT | result presented, waiting for out_ready
  // DONE     | one-cycle end-of-frame pulse
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_OUT, DONE} state_t;

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 3);
  // from the last pixel of one kernel row to the first pixel of the next
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WRAP     = ADDR_W'(3);

  state_t              state;
  logic [ADDR_W-1:0]   row, col, base, addr;
  logic [3:0]          tap;
  logic [1:0]          tx;
  logic [OADDR_W-1:0]  win;

  assign in_addr = addr;
  assign w_addr  = tap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      base      <= '0;
      addr      <= '0;
      tap       <= '0;
      tx        <= '0;
      win       <= '0;
      rd_en     <= 1'b0;
      mac_en    <= 1'b0;
      acc_load  <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // memory read latency is one cycle, so accumulator control trails rd_en
      mac_en   <= rd_en;
      acc_load <= rd_en && (tap == 4'd0);
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            row   <= '0;
            col   <= '0;
            base  <= '0;
            addr  <= '0;
            tap   <= '0;
            tx    <= '0;
            win   <= '0;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (tap == 4'd8) begin
            state <= DRAIN;
            rd_en <= 1'b0;
            tap   <= '0;
            tx    <= '0;
          end else begin
            tap <= tap + 4'd1;
            if (tx == 2'd2) begin
              tx   <= '0;
              addr <= addr + ROW_STEP;
            end else begin
              tx   <= tx + 2'd1;
              addr <= addr + ONE;
            end
          end
        end
        DRAIN: begin
          state     <= WAIT_OUT;
          out_valid <= 1'b1;
          out_addr  <= win;
        end
        WAIT_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row == ROW_LAST && col == COL_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              rd_en <= 1'b1;
              win   <= win + OADDR_W'(1);
              // base tracks row*IMG_W+col; a row wrap skips the 2 unused right-edge columns
              if (col == COL_LAST) begin
                col  <= '0;
                row  <= row + ONE;
                base <= base + WRAP;
                addr <= base + WRAP;
              end else begin
                col  <= col + ONE;
                base <= base + ONE;
                addr <= base + ONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
